// File: rtl/cplx_div_pkg.sv
// cplx_div_pkg -- shared types and constants for the sequential complex divider.
//   state_e   : controller states (IDLE, MUL, DIV, SAT, DONE)
//   WIDTH     : default packed complex word width
//   FRAC_BITS : default number of fractional bits per half
//   W, N      : half width and restoring-divider iteration count (2*W+FRAC)
//   MAXP/MAXN : signed saturation limits of one W-bit half
package cplx_div_pkg;

  localparam int WIDTH     = 48;
  localparam int FRAC_BITS = 16;
  localparam int W         = WIDTH / 2;
  localparam int N         = 2 * W + FRAC_BITS;

  localparam logic signed [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MAXN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    SAT  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/udiv_seq_lane.sv
// udiv_seq_lane -- one lane of the bit-serial restoring divider.
// Divides (num_i << LFRAC) by den_i, one quotient bit per step, MSB first.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   load_i       : load the dividend and clear remainder/quotient
//   step_i       : perform one restoring-division iteration
//   num_i        : unsigned numerator magnitude (2*LW bits)
//   den_i        : unsigned denominator (2*LW bits), stable while stepping
//   q_o          : low LW bits of the quotient
//   hi_o         : quotient has a set bit at or above bit LW (too large for LW bits)
module udiv_seq_lane
  import cplx_div_pkg::*;
#(
  parameter int LW    = W,
  parameter int LFRAC = FRAC_BITS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [2*LW-1:0] num_i,
  input  logic [2*LW-1:0] den_i,
  output logic [LW-1:0]   q_o,
  output logic            hi_o
);

  localparam int LN = 2 * LW + LFRAC;
  localparam int RW = 2 * LW;

  logic [RW-1:0] rem_q, rem_d;
  logic [LN-1:0] dvd_q, dvd_d;
  logic [LN-1:0] quo_q, quo_d;
  logic [RW:0]   trial;
  logic [RW-1:0] diff;

  always_comb begin
    rem_d = rem_q;
    dvd_d = dvd_q;
    quo_d = quo_q;
    // Shift the next dividend bit into the remainder; the remainder is always
    // below den, so the trial value needs only one extra bit.
    trial = {rem_q, dvd_q[LN-1]};
    // Only used when trial >= den, in which case the result is < den and fits RW bits.
    diff  = trial[RW-1:0] - den_i;
    if (load_i) begin
      rem_d = '0;
      dvd_d = {num_i, {LFRAC{1'b0}}};
      quo_d = '0;
    end else if (step_i) begin
      dvd_d = {dvd_q[LN-2:0], 1'b0};
      if (trial >= {1'b0, den_i}) begin
        rem_d = diff;
        quo_d = {quo_q[LN-2:0], 1'b1};
      end else begin
        rem_d = trial[RW-1:0];
        quo_d = {quo_q[LN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      dvd_q <= '0;
      quo_q <= '0;
    end else begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      quo_q <= quo_d;
    end
  end

  assign q_o  = quo_q[LW-1:0];
  assign hi_o = |quo_q[LN-1:LW];

endmodule

// File: rtl/cplx_div_seq.sv
// cplx_div_seq -- sequential fixed-point complex divider, op = in1 / in2.
// Each operand is packed {re, im}, each half signed with FRAC fractional bits.
// One product cycle, then 2*W+FRAC restoring-division cycles shared by both
// lanes against a common denominator, then one sign/saturation cycle.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   in1, in2     : dividend and divisor {re, im}
//   in_valid     : operands valid; accepted when in_ready is high
//   in_ready     : high only while idle
//   op           : quotient {re, im}, held while out_valid is high
//   out_valid    : result valid, cleared by out_ready
//   out_ready    : downstream accepts the result
//   dz           : divisor was zero (op forced to 0)
//   ovf          : re or im saturated
module cplx_div_seq
  import cplx_div_pkg::*;
#(
  parameter int width = WIDTH,
  parameter int FRAC  = FRAC_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] in1,
  input  logic [width-1:0] in2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             dz,
  output logic             ovf
);

  localparam int LW = width / 2;
  localparam int LN = 2 * LW + FRAC;
  localparam int CW = $clog2(LN);

  localparam logic [LW-1:0] SATP = (LW == W) ? MAXP : {1'b0, {(LW-1){1'b1}}};
  localparam logic [LW-1:0] SATN = (LW == W) ? MAXN : {1'b1, {(LW-1){1'b0}}};

  state_e state_q, state_d;

  logic signed [LW-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [2*LW-1:0]      den_q, den_d;
  logic                 negr_q, negr_d, negi_q, negi_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [width-1:0]     op_q, op_d;
  logic                 vld_q, vld_d, dz_q, dz_d, ovf_q, ovf_d;

  logic signed [2*LW-1:0] ac, bd, bc, ad, cc, dd;
  logic signed [2*LW:0]   numr, numi;
  logic [2*LW-1:0]        magr, magi, den_c;

  logic [LW-1:0] qr, qi;
  logic          hir, hii;
  logic [LW:0]   satr, sati;

  // Returns {overflow, value}: applies the numerator sign to the unsigned
  // quotient and clamps to the signed LW-bit range. A negative magnitude of
  // exactly 2^(LW-1) is representable and does not saturate.
  function automatic logic [LW:0] sat_lane(input logic [LW-1:0] q,
                                           input logic hi,
                                           input logic neg);
    logic          o;
    logic [LW-1:0] v;
    if (!neg) begin
      o = hi | q[LW-1];
      v = o ? SATP : q;
    end else begin
      o = hi | (q[LW-1] & (|q[LW-2:0]));
      v = o ? SATN : (~q + 1'b1);
    end
    return {o, v};
  endfunction

  // Product stage: operands are sign-extended to 2*LW before multiplying,
  // and sums keep one extra bit since |a*c + b*d| can reach 2^(2*LW-1).
  always_comb begin
    ac    = (2*LW)'(a_q) * (2*LW)'(c_q);
    bd    = (2*LW)'(b_q) * (2*LW)'(d_q);
    bc    = (2*LW)'(b_q) * (2*LW)'(c_q);
    ad    = (2*LW)'(a_q) * (2*LW)'(d_q);
    cc    = (2*LW)'(c_q) * (2*LW)'(c_q);
    dd    = (2*LW)'(d_q) * (2*LW)'(d_q);
    numr  = (2*LW+1)'(ac) + (2*LW+1)'(bd);
    numi  = (2*LW+1)'(bc) - (2*LW+1)'(ad);
    den_c = $unsigned(cc) + $unsigned(dd);
    magr  = numr[2*LW] ? (~numr[2*LW-1:0] + 1'b1) : numr[2*LW-1:0];
    magi  = numi[2*LW] ? (~numi[2*LW-1:0] + 1'b1) : numi[2*LW-1:0];
  end

  udiv_seq_lane #(.LW(LW), .LFRAC(FRAC)) u_lane_re (
    .clock  (clock),
    .reset  (reset),
    .load_i (state_q == MUL),
    .step_i (state_q == DIV),
    .num_i  (magr),
    .den_i  (den_q),
    .q_o    (qr),
    .hi_o   (hir)
  );

  udiv_seq_lane #(.LW(LW), .LFRAC(FRAC)) u_lane_im (
    .clock  (clock),
    .reset  (reset),
    .load_i (state_q == MUL),
    .step_i (state_q == DIV),
    .num_i  (magi),
    .den_i  (den_q),
    .q_o    (qi),
    .hi_o   (hii)
  );

  assign satr = sat_lane(qr, hir, negr_q);
  assign sati = sat_lane(qi, hii, negi_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    den_d   = den_q;
    negr_d  = negr_q;
    negi_d  = negi_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    vld_d   = vld_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in1[width-1:LW];
          b_d     = in1[LW-1:0];
          c_d     = in2[width-1:LW];
          d_d     = in2[LW-1:0];
          state_d = MUL;
        end
      end
      MUL: begin
        den_d   = den_c;
        negr_d  = numr[2*LW];
        negi_d  = numi[2*LW];
        cnt_d   = CW'(LN - 1);
        state_d = DIV;
      end
      DIV: begin
        if (cnt_q == '0) begin
          state_d = SAT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SAT: begin
        if (den_q == '0) begin
          op_d  = '0;
          dz_d  = 1'b1;
          ovf_d = 1'b0;
        end else begin
          op_d  = {satr[LW-1:0], sati[LW-1:0]};
          dz_d  = 1'b0;
          ovf_d = satr[LW] | sati[LW];
        end
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      den_q   <= '0;
      negr_q  <= 1'b0;
      negi_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      vld_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      den_q   <= den_d;
      negr_q  <= negr_d;
      negi_q  <= negi_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      vld_q   <= vld_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign op        = op_q;
  assign out_valid = vld_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cplx_div_seq.sv
// tb_cplx_div_seq -- directed self-checking bench for cplx_div_seq
// (defaults: 48-bit words, Q8.16 halves, 66-cycle latency).
module tb_cplx_div_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [47:0] in1, in2, op;
  logic        in_valid, in_ready, out_valid, out_ready, dz, ovf;

  int checks = 0;
  int errors = 0;
  int lat;

  cplx_div_seq dut (
    .clock     (clock),
    .reset     (reset),
    .in1       (in1),
    .in2       (in2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dz        (dz),
    .ovf       (ovf)
  );

  always #5 clock = ~clock;

  // Present one operand pair for a single cycle, then count cycles from the
  // acceptance edge until out_valid is seen (bounded).
  task automatic issue(input logic [47:0] x, input logic [47:0] y);
    @(negedge clock);
    in1 = x;
    in2 = y;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in1 = '0;
    in2 = '0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || op !== 48'h0 || dz !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b op=%h dz=%b ovf=%b, required all 0", out_valid, op, dz, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_unit();
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL unit_in_ready: got %b, required 1", in_ready);
    end
    issue({24'h010000, 24'h010000}, {24'h010000, 24'h010000});
    checks++;
    if (lat !== 66) begin
      errors++;
      $display("FAIL unit_latency: got %0d, required 66", lat);
    end
    checks++;
    if (op !== {24'h010000, 24'h000000} || dz !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL unit_result: op=%h dz=%b ovf=%b, required op=010000000000 dz=0 ovf=0", op, dz, ovf);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL unit_busy: in_ready=%b while result pending, required 0", in_ready);
    end
    ack();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL unit_ack: out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
    end
  endtask

  task automatic test_complex();
    issue({24'h010000, 24'h020000}, {24'h010000, 24'hFF0000});
    checks++;
    if (op !== {24'hFF8000, 24'h018000} || dz !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL complex_result: op=%h dz=%b ovf=%b, required ff8000018000 0 0", op, dz, ovf);
    end
    ack();
  endtask

  task automatic test_trunc();
    issue({24'h010000, 24'h000000}, {24'h030000, 24'h000000});
    checks++;
    if (op !== {24'h005555, 24'h000000} || ovf !== 1'b0) begin
      errors++;
      $display("FAIL trunc_pos: op=%h ovf=%b, required 005555000000 0", op, ovf);
    end
    ack();
    issue({24'hFF0000, 24'h000000}, {24'h030000, 24'h000000});
    checks++;
    if (op !== {24'hFFAAAB, 24'h000000} || ovf !== 1'b0) begin
      errors++;
      $display("FAIL trunc_neg: op=%h ovf=%b, required ffaaab000000 0", op, ovf);
    end
    ack();
  endtask

  task automatic test_saturation();
    issue({24'h640000, 24'h000000}, {24'h008000, 24'h000000});
    checks++;
    if (op !== {24'h7FFFFF, 24'h000000} || ovf !== 1'b1 || dz !== 1'b0) begin
      errors++;
      $display("FAIL sat_pos: op=%h ovf=%b dz=%b, required 7fffff000000 1 0", op, ovf, dz);
    end
    ack();
    issue({24'h9C0000, 24'h000000}, {24'h008000, 24'h000000});
    checks++;
    if (op !== {24'h800000, 24'h000000} || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg: op=%h ovf=%b, required 800000000000 1", op, ovf);
    end
    ack();
    // -128 / 1 lands exactly on the most negative value without saturating.
    issue({24'h800000, 24'h000000}, {24'h010000, 24'h000000});
    checks++;
    if (op !== {24'h800000, 24'h000000} || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sat_edge: op=%h ovf=%b, required 800000000000 0", op, ovf);
    end
    ack();
  endtask

  task automatic test_div_zero();
    int bad;
    issue({24'h010000, 24'h020000}, 48'h0);
    checks++;
    if (lat !== 66) begin
      errors++;
      $display("FAIL dz_latency: got %0d, required 66", lat);
    end
    checks++;
    if (op !== 48'h0 || dz !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL dz_result: op=%h dz=%b ovf=%b, required 0 1 0", op, dz, ovf);
    end
    // Hold the result with out_ready low while offering new operands.
    in1 = {24'h010000, 24'h010000};
    in2 = {24'h010000, 24'h010000};
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b1 || op !== 48'h0 || dz !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 3)
          $display("FAIL dz_hold: cycle %0d out_valid=%b op=%h dz=%b in_ready=%b, required 1 0 1 0", i, out_valid, op, dz, in_ready);
      end
    end
    in_valid = 1'b0;
    ack();
  endtask

  task automatic test_back_to_back();
    // out_ready raised early must not disturb the operation.
    @(negedge clock);
    out_ready = 1'b1;
    issue({24'h010000, 24'h020000}, {24'h010000, 24'hFF0000});
    checks++;
    if (lat !== 66 || op !== {24'hFF8000, 24'h018000}) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d op=%h, required 66 ff8000018000", lat, op);
    end
    @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
    issue({24'h010000, 24'h000000}, {24'h030000, 24'h000000});
    checks++;
    if (lat !== 66 || op !== {24'h005555, 24'h000000}) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d op=%h, required 66 005555000000", lat, op);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    in1 = {24'h640000, 24'h000000};
    in2 = {24'h008000, 24'h000000};
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op !== 48'h0 || dz !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b op=%h dz=%b ovf=%b in_ready=%b, required 0 0 0 0 1", out_valid, op, dz, ovf, in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    issue({24'h010000, 24'h010000}, {24'h010000, 24'h010000});
    checks++;
    if (lat !== 66 || op !== {24'h010000, 24'h000000} || dz !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_recover: lat=%0d op=%h dz=%b ovf=%b, required 66 010000000000 0 0", lat, op, dz, ovf);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_unit();
    test_complex();
    test_trunc();
    test_saturation();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cplx_div_seq.md
Name: cplx_div_seq

Overview:
Sequential fixed-point complex divider, the inverse operation of the packed complex multiplier datapath.
- Computes op = in1 / in2.
- Each operand is a packed {real, imag} word, each half signed two's-complement with FRAC fractional bits.
- Uses one combinational product stage and a bit-serial restoring divider shared by both output lanes.
- Sits downstream of the complex multiply stage in the equalisation/normalisation path, with a valid/ready handshake on both sides.

Parameters:
width, 48, packed complex word width; each half is W = width/2 bits signed.
FRAC, 16, number of fractional bits in each half (Q(W-FRAC).FRAC).

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
in1  input  width  dividend {re[width-1:width/2], im[width/2-1:0]}.
in2  input  width  divisor, same packing.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands (high only in IDLE).
op  output  width  quotient {re, im}; held stable while out_valid is high.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
dz  output  1  divide-by-zero flag for the current result.
ovf  output  1  saturation occurred in re or im of the current result.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state goes to IDLE.
  - op, out_valid, dz and ovf are 0; all internal registers are 0.
  - A reset asserted mid-operation aborts the operation; no partial result is output.
- Math, with a=in1.re, b=in1.im, c=in2.re, d=in2.im:
  - num_r = a*c + b*d
  - num_i = b*c - a*d
  - den = c*c + d*d
- Width rules:
  - |num| and den each fit in 2W unsigned bits; den is never negative.
  - Dividend magnitude = |num| << FRAC, which is N = 2W+FRAC bits.
  - Quotient = (|num| << FRAC) / den, unsigned and truncated.
  - Sign is then applied, so the result truncates toward zero.
- FSM:
  - IDLE: in_ready=1. When in_valid is high, capture a, b, c, d and go to MUL.
  - MUL (1 cycle): register num_r, num_i, den, and the sign bits of num_r and num_i; go to DIV.
  - DIV (exactly N cycles): restoring division, one quotient bit per cycle, MSB first. Both lanes step in parallel against the same den. An N-1..0 counter ends the state.
  - SAT (1 cycle):
    - Negate a lane if its numerator was negative.
    - Saturate to the W-bit signed range: positive overflow gives 2^(W-1)-1, negative gives -2^(W-1).
    - Write op, dz and ovf; set out_valid; go to DONE.
  - DONE: hold op and the flags. When out_ready is high, clear out_valid and go to IDLE.
- Latency:
  - Acceptance edge t0 (in_valid & in_ready).
  - out_valid rises after edge t0+N+2, i.e. 66 cycles at the defaults.
  - Latency is constant and data-independent, including the den==0 case.
- Throughput: one operation in flight. in_ready stays low from acceptance until DONE is left.
  - Consequence: a new acceptance can occur no earlier than the cycle after the out_ready handshake.
- Divide by zero (den==0): op = 0 and dz = 1 in SAT; ovf = 0.
- out_ready asserted before out_valid has no effect.
- in_valid while in_ready is low is ignored; the operands are not captured.

Decomposition:
- Package cplx_div_pkg holds:
  - state enum {IDLE, MUL, DIV, SAT, DONE}.
  - Localparams W = width/2 and N = 2*W+FRAC.
  - Constants for the saturation limits MAXP and MAXN.
- One sub-module, udiv_seq_lane, instantiated twice (re and im). Per lane it holds:
  - partial-remainder register, quotient shift register, dividend shift register.
  - Control inputs: load and step.
  - Outputs: quotient and an overflow-detect flag.
- The top level holds the FSM, products, counter, sign handling and handshake.

Test Plan:
1. (1+1i)/(1+1i): in1=in2={24'h010000,24'h010000} -> op={24'h010000,24'h000000}, dz=0, ovf=0, out_valid 66 cycles after acceptance.
2. (1+2i)/(1-1i): in1={24'h010000,24'h020000}, in2={24'h010000,24'hFF0000} -> op={24'hFF8000,24'h018000} (-0.5+1.5i).
3. Truncation toward zero: 1/3 -> re 24'h005555; -1/3 -> re 24'hFFAAAB; im 0 in both cases; ovf=0.
4. Saturation: 100/0.5 (in1.re=24'h640000, in2.re=24'h008000, imags 0) -> op.re=24'h7FFFFF, ovf=1.
5. Divide by zero: in2=0, in1 arbitrary -> op=0, dz=1, latency still 66 cycles. Then hold out_ready=0 for 10 cycles -> op and out_valid stay stable and in_ready stays 0.
6. Reset mid-DIV: assert reset 20 cycles after acceptance -> out_valid, op, dz and ovf all 0 immediately, with no clock edge needed. After release, in_ready=1 and a new operation (scenario 1) completes correctly.
